// File: rtl/mips_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_seq_pkg : shared state encodings and default widths for the boot sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_seq_pkg;

  localparam int c_DEF_DATA_WIDTH = 32;
  localparam int c_DEF_IMEM_AW    = 8;
  localparam int c_DEF_CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_seq_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_seq_loader : host word handshake, word index and registered imem write
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_seq_loader
  import mips_seq_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int IMEM_AW    = c_DEF_IMEM_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [IMEM_AW:0]      i_load_len,
  input  logic                  i_host_valid,
  input  logic [DATA_WIDTH-1:0] i_host_data,
  output logic                  o_host_ready,
  output logic                  o_imem_we,
  output logic [IMEM_AW+1:0]    o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wd,
  output logic                  o_last
);

  localparam logic [IMEM_AW:0] c_DEPTH   = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW:0] c_IDX_ONE = {{IMEM_AW{1'b0}}, 1'b1};

  logic [IMEM_AW:0]      r_idx;
  logic [IMEM_AW:0]      r_len;
  logic                  r_ready;
  logic                  r_we;
  logic [IMEM_AW+1:0]    r_addr;
  logic [DATA_WIDTH-1:0] r_wd;
  logic [IMEM_AW:0]      w_len_clamped;
  logic [IMEM_AW:0]      w_idx_inc;
  logic                  w_accept;

  // Oversized loads stop at the end of memory instead of wrapping to address 0.
  assign w_len_clamped = (i_load_len > c_DEPTH) ? c_DEPTH : i_load_len;
  assign w_accept      = i_host_valid & r_ready;
  assign w_idx_inc     = r_idx + c_IDX_ONE;
  assign o_last        = w_accept & (w_idx_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_start) begin
        r_idx   <= '0;
        r_len   <= w_len_clamped;
        r_ready <= 1'b1;
      end else if (w_accept) begin
        r_we   <= 1'b1;
        r_addr <= {r_idx[IMEM_AW-1:0], 2'b00};
        r_wd   <= i_host_data;
        r_idx  <= w_idx_inc;
        if (w_idx_inc == r_len) begin
          r_ready <= 1'b0;
        end
      end
    end
  end

  assign o_host_ready = r_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wd    = r_wd;

endmodule
`default_nettype wire

// File: rtl/mips_boot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_boot_sequencer : load / commit / run / halt control of the MIPS core
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_boot_sequencer
  import mips_seq_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int IMEM_AW    = c_DEF_IMEM_AW,
  parameter int CNT_WIDTH  = c_DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_load,
  input  logic [IMEM_AW:0]      load_len,
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ready,
  output logic                  imem_we,
  output logic [IMEM_AW+1:0]    imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wd,
  input  logic [CNT_WIDTH-1:0]  run_limit,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  cpu_rst_n,
  output logic                  cpu_clk_en,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [2:0]            state,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  seq_state_t           r_state;
  seq_state_t           w_next;
  logic                 w_load_start;
  logic                 w_last;
  logic                 w_limit_hit;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_limit;
  logic                 r_cpu_rst_n;
  logic                 r_clk_en;
  logic                 r_done;

  mips_seq_loader #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMEM_AW    (IMEM_AW)
  ) u_loader (
    .clk          (CLK),
    .rst_n        (RST),
    .i_start      (w_load_start),
    .i_load_len   (load_len),
    .i_host_valid (host_valid),
    .i_host_data  (host_data),
    .o_host_ready (host_ready),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wd    (imem_wd),
    .o_last       (w_last)
  );

  // ">=" rather than "==" so a resume past the budget still halts after one cycle.
  assign w_limit_hit = (r_limit != '0) && (r_cnt >= (r_limit - c_CNT_ONE));

  always_comb begin
    w_next       = r_state;
    w_load_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_load) begin
          w_load_start = (load_len != '0);
          w_next       = (load_len != '0) ? ST_LOAD : ST_COMMIT;
        end
      end
      ST_LOAD: begin
        if (w_last) w_next = ST_COMMIT;
      end
      ST_COMMIT: w_next = ST_RUN;
      ST_RUN: begin
        if (halt_req || w_limit_hit) w_next = ST_HALT;
      end
      ST_HALT: begin
        if (start_load) begin
          w_load_start = (load_len != '0);
          w_next       = (load_len != '0) ? ST_LOAD : ST_COMMIT;
        end else if (resume && !halt_req) begin
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Core controls are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cpu_rst_n <= 1'b0;
      r_clk_en    <= 1'b1;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_limit     <= '0;
    end else begin
      r_cpu_rst_n <= (w_next == ST_RUN) || (w_next == ST_HALT);
      r_clk_en    <= (w_next != ST_HALT);
      r_done      <= (w_next == ST_HALT);
      if ((w_next == ST_LOAD) || (w_next == ST_COMMIT)) begin
        r_cnt <= '0;
      end else if ((r_state == ST_RUN) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (r_state == ST_COMMIT) begin
        r_limit <= run_limit;
      end
    end
  end

  assign cpu_rst_n  = r_cpu_rst_n;
  assign cpu_clk_en = r_clk_en;
  assign cycle_cnt  = r_cnt;
  assign state      = r_state;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_boot_sequencer : scoreboard bench for the boot sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mips_boot_sequencer;

  logic        CLK;
  logic        RST;
  logic        start_load;
  logic [8:0]  load_len;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wd;
  logic [31:0] run_limit;
  logic        halt_req;
  logic        resume;
  logic        cpu_rst_n;
  logic        cpu_clk_en;
  logic [31:0] cycle_cnt;
  logic [2:0]  state;
  logic        done;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_writes = 0;

  mips_boot_sequencer #(.DATA_WIDTH(32), .IMEM_AW(8), .CNT_WIDTH(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_load (start_load),
    .load_len   (load_len),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .run_limit  (run_limit),
    .halt_req   (halt_req),
    .resume     (resume),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_clk_en (cpu_clk_en),
    .cycle_cnt  (cycle_cnt),
    .state      (state),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Every imem write must match the oldest word the bench expects.
  always @(negedge CLK) begin
    wr_t e;
    if (RST === 1'b1 && imem_we === 1'b1) begin
      n_writes++;
      n_checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wd);
      end else begin
        e = q.pop_front();
        if ({imem_addr, imem_wd} !== {e.addr, e.data})
          $display("FAIL imem_write: got addr %0h data %0h, expected addr %0h data %0h", imem_addr, imem_wd, e.addr, e.data);
        else n_pass++;
      end
    end
  end

  task automatic do_load(input int len, input bit toggle);
    int eff, idx, k;
    bit exp_we, vld;
    wr_t e;
    eff = (len > 256) ? 256 : len;
    start_load = 1'b1; load_len = 9'(len);
    @(negedge CLK);
    start_load = 1'b0;
    idx = 0; k = 0; exp_we = 1'b0;
    while ((idx < eff || exp_we) && k < 2000) begin
      n_checks++; if (state !== ((idx < eff) ? 3'd1 : 3'd2)) $display("FAIL load_state: got %0d expected %0d", state, (idx < eff) ? 1 : 2); else n_pass++;
      n_checks++; if (host_ready !== (idx < eff)) $display("FAIL load_ready: got %b expected %b", host_ready, (idx < eff)); else n_pass++;
      n_checks++; if (imem_we !== exp_we) $display("FAIL load_we: got %b expected %b", imem_we, exp_we); else n_pass++;
      n_checks++; if ({cpu_rst_n, cycle_cnt} !== 33'd0) $display("FAIL load_core_held: got rst_n %b cnt %0d expected 0 0", cpu_rst_n, cycle_cnt); else n_pass++;
      vld = toggle ? (k % 2 == 0) : 1'b1;
      host_valid = vld;
      host_data  = $urandom;
      start_load = (k == 2) && (idx < eff);
      exp_we = 1'b0;
      if (vld && idx < eff) begin
        e.addr = 10'(idx * 4); e.data = host_data;
        q.push_back(e);
        idx++;
        exp_we = 1'b1;
      end
      @(negedge CLK);
      k++;
    end
    host_valid = 1'b0; start_load = 1'b0;
    n_checks++; if (k >= 2000) $display("FAIL load_timeout: got %0d words expected %0d", idx, eff); else n_pass++;
    n_checks++; if ({state, cpu_rst_n, cpu_clk_en} !== {3'd3, 1'b1, 1'b1}) $display("FAIL run_entry: got state %0d rst_n %b clk_en %b expected 3 1 1", state, cpu_rst_n, cpu_clk_en); else n_pass++;
  endtask

  task automatic wait_halt(output int runs);
    int b;
    runs = 0; b = 0;
    while (state == 3'd3 && b < 1000) begin
      if (cpu_clk_en) runs++;
      @(negedge CLK);
      b++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; start_load = 0; load_len = 0; host_valid = 0; host_data = 0;
    run_limit = 0; halt_req = 0; resume = 0;
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if ({state, cpu_rst_n, cpu_clk_en, imem_we, imem_addr, imem_wd, host_ready, cycle_cnt, done} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_values: got state %0d rst_n %b clk_en %b we %b ready %b cnt %0d done %b, expected 0 0 1 0 0 0 0",
               state, cpu_rst_n, cpu_clk_en, imem_we, host_ready, cycle_cnt, done);
    else n_pass++;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_load_stream_and_limit;
    int runs;
    run_limit = 32'd10;
    do_load(4, 1'b0);
    n_checks++; if (cycle_cnt !== 32'd0) $display("FAIL run_cnt_start: got %0d expected 0", cycle_cnt); else n_pass++;
    wait_halt(runs);
    n_checks++; if (runs !== 10) $display("FAIL limit_cycles: got %0d expected 10", runs); else n_pass++;
    n_checks++; if ({state, cycle_cnt, done, cpu_rst_n, cpu_clk_en} !== {3'd4, 32'd10, 1'b1, 1'b1, 1'b0})
      $display("FAIL limit_halt: got state %0d cnt %0d done %b rst_n %b clk_en %b expected 4 10 1 1 0", state, cycle_cnt, done, cpu_rst_n, cpu_clk_en); else n_pass++;
  endtask

  task automatic test_toggle_and_halt_req;
    int b;
    run_limit = 32'd0;
    do_load(3, 1'b1);
    b = 0;
    while (cycle_cnt !== 32'd4 && b < 100) begin @(negedge CLK); b++; end
    halt_req = 1'b1;
    @(negedge CLK);
    n_checks++; if ({state, cycle_cnt, done} !== {3'd4, 32'd5, 1'b1}) $display("FAIL halt_req: got state %0d cnt %0d done %b expected 4 5 1", state, cycle_cnt, done); else n_pass++;
    resume = 1'b1;
    @(negedge CLK); resume = 1'b0;
    n_checks++; if ({state, cycle_cnt} !== {3'd4, 32'd5}) $display("FAIL resume_blocked: got state %0d cnt %0d expected 4 5", state, cycle_cnt); else n_pass++;
    halt_req = 1'b0; resume = 1'b1;
    @(negedge CLK); resume = 1'b0;
    n_checks++; if ({state, cycle_cnt, cpu_clk_en} !== {3'd3, 32'd5, 1'b1}) $display("FAIL resume: got state %0d cnt %0d clk_en %b expected 3 5 1", state, cycle_cnt, cpu_clk_en); else n_pass++;
    @(negedge CLK);
    n_checks++; if (cycle_cnt !== 32'd6) $display("FAIL resume_count: got %0d expected 6", cycle_cnt); else n_pass++;
    halt_req = 1'b1;
    @(negedge CLK); halt_req = 1'b0;
    n_checks++; if ({state, cycle_cnt} !== {3'd4, 32'd7}) $display("FAIL rehalt: got state %0d cnt %0d expected 4 7", state, cycle_cnt); else n_pass++;
  endtask

  task automatic test_clamp;
    int w0, runs;
    run_limit = 32'd2;
    w0 = n_writes;
    do_load(300, 1'b0);
    n_checks++; if (n_writes - w0 !== 256) $display("FAIL clamp_writes: got %0d expected 256", n_writes - w0); else n_pass++;
    n_checks++; if (imem_addr !== 10'h3FC) $display("FAIL clamp_last_addr: got %0h expected 3fc", imem_addr); else n_pass++;
    wait_halt(runs);
    n_checks++; if (runs !== 2) $display("FAIL clamp_run: got %0d expected 2", runs); else n_pass++;
  endtask

  task automatic test_reset_mid_load;
    int runs;
    wr_t e;
    start_load = 1'b1; load_len = 9'd4; host_valid = 1'b1;
    @(negedge CLK); start_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      host_data = $urandom;
      e.addr = 10'(i * 4); e.data = host_data;
      q.push_back(e);
      @(negedge CLK);
    end
    host_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if ({state, cpu_rst_n, cpu_clk_en, imem_we, imem_addr, imem_wd, host_ready, cycle_cnt, done} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_mid_load: got state %0d rst_n %b we %b addr %0h ready %b, expected 0 0 0 0 0", state, cpu_rst_n, imem_we, imem_addr, host_ready);
    else n_pass++;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    n_checks++; if ({state, cpu_rst_n} !== {3'd0, 1'b0}) $display("FAIL idle_after_reset: got state %0d rst_n %b expected 0 0", state, cpu_rst_n); else n_pass++;
    run_limit = 32'd3;
    do_load(2, 1'b0);
    wait_halt(runs);
    n_checks++; if ({state, cycle_cnt} !== {3'd4, 32'd3} || runs !== 3) $display("FAIL restart_run: got state %0d cnt %0d runs %0d expected 4 3 3", state, cycle_cnt, runs); else n_pass++;
    resume = 1'b1;
    @(negedge CLK); resume = 1'b0;
    wait_halt(runs);
    n_checks++; if ({state, cycle_cnt} !== {3'd4, 32'd4} || runs !== 1) $display("FAIL resume_past_limit: got state %0d cnt %0d runs %0d expected 4 4 1", state, cycle_cnt, runs); else n_pass++;
  endtask

  task automatic test_zero_len;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    run_limit = 32'd0;
    start_load = 1'b1; load_len = 9'd0;
    @(negedge CLK); start_load = 1'b0;
    n_checks++; if ({state, cpu_rst_n, host_ready} !== {3'd2, 1'b0, 1'b0}) $display("FAIL zero_len_commit: got state %0d rst_n %b ready %b expected 2 0 0", state, cpu_rst_n, host_ready); else n_pass++;
    @(negedge CLK);
    n_checks++; if ({state, cpu_rst_n} !== {3'd3, 1'b1}) $display("FAIL zero_len_run: got state %0d rst_n %b expected 3 1", state, cpu_rst_n); else n_pass++;
    halt_req = 1'b1;
    @(negedge CLK); halt_req = 1'b0;
    n_checks++; if (state !== 3'd4) $display("FAIL zero_len_halt: got %0d expected 4", state); else n_pass++;
    n_checks++; if (q.size() !== 0) $display("FAIL pending_writes: got %0d expected 0", q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_stream_and_limit();
    test_toggle_and_halt_req();
    test_clamp();
    test_reset_mid_load();
    test_zero_len();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_boot_sequencer.md
Name: mips_boot_sequencer

Overview:
- Sequences the single-cycle MIPS core through load, run and halt phases.
- Accepts program words from a host over a valid/ready stream and writes them into instruction memory while holding the core in reset.
- Releases the core, then halts it after a programmable cycle budget or on request.
- Sits between the host/test harness and the core's reset, clock-enable and instruction-memory write port.

Parameters:
DATA_WIDTH, 32, instruction word width
IMEM_AW, 8, instruction memory word-address width (depth 2^IMEM_AW words)
CNT_WIDTH, 32, run-cycle counter and budget width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
start_load  in  1  single-cycle pulse: begin program load
load_len  in  IMEM_AW+1  number of words to load; sampled on start_load
host_valid  in  1  host word valid
host_data  in  DATA_WIDTH  host word
host_ready  out  1  sequencer accepts a word this cycle
imem_we  out  1  instruction memory write enable
imem_addr  out  IMEM_AW+2  instruction memory byte address (word index << 2)
imem_wd  out  DATA_WIDTH  instruction memory write data
run_limit  in  CNT_WIDTH  run budget in cycles; 0 = unlimited; sampled on entry to RUN
halt_req  in  1  level: halt core
resume  in  1  single-cycle pulse: HALT -> RUN
cpu_rst_n  out  1  drives core RST (active-low)
cpu_clk_en  out  1  core clock enable (gate cell external)
cycle_cnt  out  CNT_WIDTH  core cycles executed since last load
state  out  3  current state encoding
done  out  1  high while in HALT

Behaviour:
- All outputs registered. On RST low (asynchronous):
  - state=IDLE, cpu_rst_n=0, cpu_clk_en=1.
  - imem_we=0, imem_addr=0, imem_wd=0, host_ready=0.
  - cycle_cnt=0, done=0. Internal word index and length are cleared.
- States: IDLE=0, LOAD=1, COMMIT=2, RUN=3, HALT=4. Encodings live in the shared package.
- IDLE:
  - cpu_rst_n=0.
  - start_load with load_len>0 -> LOAD; word index cleared, length latched.
  - start_load with load_len=0 -> COMMIT; empty load, program memory unchanged.
- Length clamp: load_len > 2^IMEM_AW is clamped to 2^IMEM_AW. Addresses never wrap.
- LOAD:
  - cpu_rst_n=0, cycle_cnt cleared, host_ready=1.
  - A word is accepted on host_valid&host_ready.
  - Cycle after acceptance: imem_we=1 for exactly one cycle, imem_addr=index<<2, imem_wd=accepted data. The index then increments.
  - host_ready drops in the cycle after the last word is accepted. State -> COMMIT.
  - host_valid with ready low: no effect.
  - start_load during LOAD is ignored.
- COMMIT:
  - Single cycle; the final imem write completes here.
  - cpu_rst_n stays 0. Next state: RUN.
- RUN:
  - cpu_rst_n=1, cpu_clk_en=1.
  - cycle_cnt increments each cycle and saturates at all-ones.
  - run_limit latched on entry.
  - Exit to HALT when halt_req=1, or when the limit is non-zero and cycle_cnt==limit-1 (exactly `limit` core cycles execute). Both conditions in the same cycle -> HALT.
  - start_load and resume are ignored.
- HALT:
  - cpu_clk_en=0, cpu_rst_n=1 (core and data memory state preserved), done=1.
  - resume with halt_req=0 -> RUN; cycle_cnt continues, limit not re-latched.
  - A limit-caused halt with cycle_cnt>=limit halts again after one core cycle on resume.
  - start_load -> LOAD; cpu_rst_n=0 from the next cycle.
  - start_load and resume together: start_load wins.
- Reset mid-LOAD: a partial program stays in memory. The sequencer returns to IDLE with the core in reset.

Decomposition:
- Package mips_seq_pkg holds:
  - state enum/localparams (IDLE..HALT, 3 bits)
  - default widths (IMEM_AW, CNT_WIDTH)
- One natural sub-module: mips_seq_loader, the LOAD-phase handshake, index counter and imem write register. The top FSM owns the RUN/HALT counter and the core controls.

Test Plan:
- Reset, then start_load, load_len=4, host streams 4 words with valid held high -> imem writes at byte addr 0,4,8,12 on consecutive cycles. COMMIT for one cycle, then RUN with cpu_rst_n=1.
- load_len=3, host_valid toggles 1,0,1,0,1 -> exactly 3 imem_we pulses with matching data. No write on idle cycles; host_ready=0 after the third accept.
- run_limit=10 -> cpu_clk_en high for exactly 10 RUN cycles. HALT with cycle_cnt=10, done=1, cpu_rst_n=1.
- run_limit=0, halt_req asserted at run cycle 5 -> HALT with cycle_cnt=5. Pulse resume after halt_req drops -> RUN, and cycle_cnt resumes from 5.
- load_len=300 with IMEM_AW=8 -> exactly 256 writes, last imem_addr=0x3FC, no wrap to 0.
- RST low mid-LOAD after 2 of 4 words -> all outputs at reset values immediately. start_load afterwards restarts at imem_addr 0.
